// File: rtl/display_panel_receiver.sv
// Panel-side model of the serial row/col interface: shifts column bits, latches them, times oe,
// then streams the latched row as column words. Optional: DISPLAY_RX_SKIP_BLANK_EN drops blank rows.
module display_panel_receiver #(
    parameter int unsigned Segments    = 1,
    parameter int unsigned Rows        = 8,
    parameter int unsigned Columns     = 32,
    parameter int unsigned WeightWidth = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_oclk,
    input  logic                       i_lat,
    input  logic                       i_oe,
    input  logic [3*Segments-1:0]      i_rgb,
    input  logic [$clog2(Rows)-1:0]    i_row,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [$clog2(Rows)-1:0]    o_out_row,
    output logic [$clog2(Columns)-1:0] o_out_column,
    output logic [3*Segments-1:0]      o_out_bits,
    output logic [WeightWidth-1:0]     o_out_weight,
    output logic                       o_out_last,
    output logic                       o_len_err,
    output logic                       o_proto_err,
    output logic                       o_overflow,
    input  logic                       i_err_clr
);

    localparam int unsigned Bw   = 3 * Segments;
    localparam int unsigned RowW = $clog2(Rows);
    localparam int unsigned ColW = $clog2(Columns);
    localparam int unsigned CntW = $clog2(Columns + 2);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArmed   = 2'd1;
    localparam logic [1:0] StDisplay = 2'd2;
    localparam logic [1:0] StEmit    = 2'd3;

    logic                         r_s_oclk, r_s_lat, r_s_oe;
    logic                         r_d_oclk, r_d_lat, r_d_oe;
    logic [Bw-1:0]                r_s_rgb;
    logic [RowW-1:0]              r_s_row;
    logic [Columns-1:0][Bw-1:0]   r_sreg;
    logic [Columns-1:0][Bw-1:0]   r_hold;
    logic [RowW-1:0]              r_hold_row;
    logic [WeightWidth-1:0]       r_weight;
    logic [CntW-1:0]              r_shift_cnt;
    logic [1:0]                   r_state;
    logic [ColW-1:0]              r_col;
    logic                         r_valid;
    logic                         r_len_err, r_proto_err, r_overflow;

    logic                         w_oclk_rise, w_lat_rise, w_oe_fall;
    logic [Columns-1:0][Bw-1:0]   w_sreg_nxt;
    logic [CntW-1:0]              w_cnt_nxt;
    logic                         w_len_bad, w_accept, w_last_col, w_skip;
    logic [WeightWidth-1:0]       w_weight_inc, w_weight_nxt;
    logic [1:0]                   w_state_nxt;
    logic [ColW-1:0]              w_col_nxt;
    logic                         w_valid_nxt, w_latch, w_drop;

    assign w_oclk_rise = r_s_oclk & ~r_d_oclk;
    assign w_lat_rise  = r_s_lat & ~r_d_lat;
    assign w_oe_fall   = ~r_s_oe & r_d_oe;

    // Column 0 receives the newest bit, so the first-shifted bit ends at Columns-1.
    assign w_sreg_nxt = w_oclk_rise ? {r_sreg[Columns-2:0], r_s_rgb} : r_sreg;
    assign w_cnt_nxt  = (w_oclk_rise && (r_shift_cnt != CntW'(Columns + 1))) ?
                        r_shift_cnt + 1'b1 : r_shift_cnt;
    assign w_len_bad  = (w_cnt_nxt != CntW'(Columns));

    assign w_accept     = r_valid & i_out_ready;
    assign w_last_col   = (r_col == ColW'(Columns - 1));
    assign w_weight_inc = (r_weight == '1) ? r_weight : r_weight + 1'b1;

`ifdef DISPLAY_RX_SKIP_BLANK_EN
    assign w_skip = (r_hold == '0) || (r_weight == '0);
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_weight_nxt = r_weight;
        w_col_nxt    = r_col;
        w_valid_nxt  = r_valid;
        w_latch      = 1'b0;
        w_drop       = 1'b0;
        if (w_lat_rise) begin
            if (r_state == StEmit) w_drop = 1'b1;
            else                   w_latch = 1'b1;
        end
        case (r_state)
            StArmed: begin
                if (r_s_oe) begin
                    w_state_nxt  = StDisplay;
                    w_weight_nxt = w_weight_inc;
                end
            end
            StDisplay: begin
                if (w_oe_fall) begin
                    w_state_nxt = w_skip ? StIdle : StEmit;
                    w_col_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (r_s_oe) begin
                    w_weight_nxt = w_weight_inc;
                end
            end
            StEmit: begin
                // One idle cycle on entry, then words advance on each handshake.
                if (!r_valid) begin
                    w_valid_nxt = 1'b1;
                end else if (w_accept) begin
                    if (w_last_col) begin
                        w_valid_nxt = 1'b0;
                        w_col_nxt   = '0;
                        w_state_nxt = StIdle;
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (w_latch) begin
            w_weight_nxt = '0;
            w_state_nxt  = r_s_oe ? StDisplay : StArmed;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_oclk    <= 1'b0;
            r_s_lat     <= 1'b0;
            r_s_oe      <= 1'b0;
            r_d_oclk    <= 1'b0;
            r_d_lat     <= 1'b0;
            r_d_oe      <= 1'b0;
            r_s_rgb     <= '0;
            r_s_row     <= '0;
            r_sreg      <= '0;
            r_hold      <= '0;
            r_hold_row  <= '0;
            r_weight    <= '0;
            r_shift_cnt <= '0;
            r_state     <= StIdle;
            r_col       <= '0;
            r_valid     <= 1'b0;
            r_len_err   <= 1'b0;
            r_proto_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_s_oclk    <= i_oclk;
            r_s_lat     <= i_lat;
            r_s_oe      <= i_oe;
            r_d_oclk    <= r_s_oclk;
            r_d_lat     <= r_s_lat;
            r_d_oe      <= r_s_oe;
            r_s_rgb     <= i_rgb;
            r_s_row     <= i_row;
            r_sreg      <= w_sreg_nxt;
            r_shift_cnt <= w_lat_rise ? '0 : w_cnt_nxt;
            if (w_latch) begin
                r_hold     <= w_sreg_nxt;
                r_hold_row <= r_s_row;
            end
            r_weight    <= w_weight_nxt;
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_valid     <= w_valid_nxt;
            r_len_err   <= (r_len_err & ~i_err_clr) | (w_latch & w_len_bad);
            r_proto_err <= (r_proto_err & ~i_err_clr) | (w_lat_rise & r_s_oe);
            r_overflow  <= (r_overflow & ~i_err_clr) | w_drop;
        end
    end

    assign o_out_valid  = r_valid;
    assign o_out_row    = r_hold_row;
    assign o_out_column = r_col;
    assign o_out_bits   = r_hold[r_col];
    assign o_out_weight = r_weight;
    assign o_out_last   = r_valid & w_last_col;
    assign o_len_err    = r_len_err;
    assign o_proto_err  = r_proto_err;
    assign o_overflow   = r_overflow;

endmodule
